// File: rtl/subtractor_pipe.sv
// -----------------------------------------------------------------------------
// subtractor_pipe
//
// Two-stage pipelined WIDTH-bit subtractor with borrow in/out:
//   diff = (A - B - bin) mod 2^WIDTH
// It carries the SUB/compare path of the ALU datapath: the difference, the
// unsigned borrow out, the signed overflow flag and the zero flag.
//
// Stage 1 subtracts the low SPLIT bits and keeps the internal borrow plus the
// high operand parts. Stage 2 subtracts the high parts using that borrow. It
// then registers the full result and its flags.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operands on sub_inA/sub_inB/bin are valid
//   in_ready   out  1      block accepts operands this cycle
//   sub_inA    in   WIDTH  minuend
//   sub_inB    in   WIDTH  subtrahend
//   bin        in   1      borrow in (1 = subtract one extra)
//   out_valid  out  1      diff/bout/ovf/zero hold a valid result
//   out_ready  in   1      consumer takes the result this cycle
//   diff       out  WIDTH  (A - B - bin) mod 2^WIDTH
//   bout       out  1      unsigned borrow out: 1 iff A < B + bin
//   ovf        out  1      signed overflow of the subtraction
//   zero       out  1      diff == 0
//
// Handshake: a transfer happens on a port only at a rising edge where valid
// and ready are both 1. Once a source raises valid, it holds valid and its
// data until that transfer. in_ready depends only on pipeline state and
// out_ready, and never on in_valid.
// -----------------------------------------------------------------------------
module subtractor_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sub_inA,
  input  logic [WIDTH-1:0] sub_inB,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int HW = WIDTH - SPLIT;

  // Stage 1 registers
  logic             s1_valid;
  logic [SPLIT-1:0] s1_low;
  logic             s1_b1;
  logic [HW-1:0]    s1_a_hi;
  logic [HW-1:0]    s1_b_hi;

  // Pipeline control
  logic out_clear;
  logic s1_advance;
  logic accept;

  // Datapath
  logic [SPLIT:0]   low_ext;
  logic [HW:0]      high_ext;
  logic [WIDTH-1:0] diff_next;
  logic             ovf_next;

  // The output register can take new data when it is empty or being drained.
  assign out_clear  = !out_valid || out_ready;
  assign s1_advance = s1_valid && out_clear;
  assign in_ready   = !s1_valid || out_clear;
  assign accept     = in_valid && in_ready;

  // Both operands are zero-extended by one bit. The extra top bit of the
  // result is then 1 exactly when the part went negative, which is the
  // borrow out of that part.
  always_comb begin
    low_ext  = {1'b0, sub_inA[SPLIT-1:0]} - {1'b0, sub_inB[SPLIT-1:0]}
             - {{SPLIT{1'b0}}, bin};
    high_ext = {1'b0, s1_a_hi} - {1'b0, s1_b_hi} - {{HW{1'b0}}, s1_b1};
    diff_next = {high_ext[HW-1:0], s1_low};
    // Overflow can only happen when the operand signs differ. It is flagged
    // when the result sign does not match the minuend sign.
    ovf_next = (s1_a_hi[HW-1] != s1_b_hi[HW-1]) &&
               (high_ext[HW-1] != s1_a_hi[HW-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_low    <= '0;
      s1_b1     <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      // Stage 1: a new accept wins over emptying. When both happen in the
      // same cycle, stage 1 simply refills and no bubble appears.
      if (accept) begin
        s1_valid <= 1'b1;
        s1_low   <= low_ext[SPLIT-1:0];
        s1_b1    <= low_ext[SPLIT];
        s1_a_hi  <= sub_inA[WIDTH-1:SPLIT];
        s1_b_hi  <= sub_inB[WIDTH-1:SPLIT];
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end

      // Stage 2 / output register. The result fields only change when new
      // data loads, so they stay stable while the output is stalled.
      if (s1_advance) begin
        out_valid <= 1'b1;
        diff      <= diff_next;
        bout      <= high_ext[HW];
        ovf       <= ovf_next;
        zero      <= (diff_next == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// tb_subtractor_pipe
//
// Directed and random checks of subtractor_pipe (WIDTH=32, SPLIT=16).
// Results are compared as {bout, ovf, zero, diff} (35 bits).
// -----------------------------------------------------------------------------
module tb_subtractor_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sub_inA;
  logic [31:0] sub_inB;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];

  // Shared directed table: A, B, bin and the hand-computed {bout,ovf,zero,diff}
  logic [31:0] tab_a  [8];
  logic [31:0] tab_b  [8];
  logic        tab_bin[8];
  logic [34:0] tab_exp[8];

  subtractor_pipe #(.WIDTH(32), .SPLIT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub_inA   (sub_inA),
    .sub_inB   (sub_inB),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver: push one operation into an empty pipe with out_ready=1 and wait
  // for its result. lat counts rising edges from the capture edge (inclusive)
  // up to the edge after which out_valid is first seen.
  // ---------------------------------------------------------------------------
  task automatic run_single(input logic [31:0] a, input logic [31:0] b,
                            input logic bi, output logic [34:0] res,
                            output int lat, output logic timed_out);
    sub_inA   = a;
    sub_inB   = b;
    bin       = bi;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    timed_out = !out_valid;
    res = {bout, ovf, zero, diff};
    @(posedge clk); #1;
  endtask

  // Independent reference: a full-width 33-bit subtraction.
  function automatic logic [34:0] ref_model(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic bi);
    logic [32:0] full;
    logic        v;
    full = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    v    = (a[31] != b[31]) && (full[31] != a[31]);
    return {full[32], v, (full[31:0] == 32'd0), full[31:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sub_inA = '0; sub_inB = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, bout, ovf, zero, diff} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got out_valid=%0b bout=%0b ovf=%0b zero=%0b diff=%h, expected all 0",
               out_valid, bout, ovf, zero, diff);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%0b out_valid=%0b, expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] va  [6];
    logic [31:0] vb  [6];
    logic        vbin[6];
    logic [34:0] vexp[6];
    logic [34:0] res;
    int          lat;
    logic        to;
    va   = '{32'h0000_0005, 32'h0000_0000, 32'h0001_0000, 32'h8000_0000, 32'h1234_5678, 32'h0000_0000};
    vb   = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h1234_5678, 32'h0000_0000};
    vbin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vexp = '{{3'b000, 32'h0000_0002},
             {3'b100, 32'hFFFF_FFFF},
             {3'b000, 32'h0000_FFFF},
             {3'b010, 32'h7FFF_FFFF},
             {3'b001, 32'h0000_0000},
             {3'b100, 32'hFFFF_FFFF}};
    for (int i = 0; i < 6; i++) begin
      run_single(va[i], vb[i], vbin[i], res, lat, to);
      checks++;
      if (to || lat != 2) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got %0d edges (timeout=%0b), expected 2", i, lat, to);
      end
      checks++;
      if (res !== vexp[i]) begin
        errors++;
        $display("FAIL basic_result[%0d]: got bout/ovf/zero=%b diff=%h, expected %b diff=%h",
                 i, res[34:32], res[31:0], vexp[i][34:32], vexp[i][31:0]);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drained: got out_valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int sent  = 0;
    int got   = 0;
    int first = -1;
    int last  = -1;
    int cyc   = 0;
    exp_q.delete();
    out_ready = 1'b1;
    while ((sent < 8 || got < 8) && cyc < 30) begin
      if (sent < 8) begin
        sub_inA = tab_a[sent]; sub_inB = tab_b[sent]; bin = tab_bin[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (sent < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready[%0d]: got %0b, expected 1", sent, in_ready);
        end
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got diff=%h with nothing expected", diff);
        end else if ({bout, ovf, zero, diff} !== exp_q[0]) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %b diff=%h, expected %b diff=%h",
                   got, {bout, ovf, zero}, diff, exp_q[0][34:32], exp_q[0][31:0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(tab_exp[sent]);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8 || last - first != 7) begin
      errors++;
      $display("FAIL b2b_stream: got %0d results over %0d cycles, expected 8 over 8", got, last - first + 1);
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    int got = 0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sub_inA = tab_a[acc]; sub_inB = tab_b[acc]; bin = tab_bin[acc];
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        exp_q.push_back(tab_exp[acc]);
        acc++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (acc != 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_accepts: got %0d accepts, in_ready=%0b, expected 2 and 0", acc, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || {bout, ovf, zero, diff} !== tab_exp[0]) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%0b %b diff=%h, expected 1 %b diff=%h",
                 c, out_valid, {bout, ovf, zero}, diff, tab_exp[0][34:32], tab_exp[0][31:0]);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stall_dup: got diff=%h with nothing expected", diff);
        end else begin
          if ({bout, ovf, zero, diff} !== exp_q[0]) begin
            errors++;
            $display("FAIL stall_drain[%0d]: got %b diff=%h, expected %b diff=%h",
                     got, {bout, ovf, zero}, diff, exp_q[0][34:32], exp_q[0][31:0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count: got %0d results, expected 2", got);
    end
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sub_inA = tab_a[i]; sub_inB = tab_b[i]; bin = tab_bin[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: got out_valid=%0b in_ready=%0b, expected 1/0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, bout, ovf, zero, diff} !== {2'b01, 3'b000, 32'd0}) begin
      errors++;
      $display("FAIL flush_state: got out_valid=%0b in_ready=%0b flags=%b diff=%h, expected 0 1 000 00000000",
               out_valid, in_ready, {bout, ovf, zero}, diff);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_ghost: got %0d results after reset, expected 0", seen);
    end
  endtask

  task automatic test_random();
    int   n_ops    = 10000;
    int   accepted = 0;
    int   received = 0;
    int   cyc      = 0;
    logic pending  = 1'b0;
    exp_q.delete();
    while ((accepted < n_ops || exp_q.size() != 0) && cyc < 80000) begin
      if (!pending && accepted < n_ops && $urandom_range(0, 3) != 0) begin
        sub_inA = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
        sub_inB = ($urandom_range(0, 15) == 0) ? sub_inA : $urandom();
        bin     = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got diff=%h with nothing expected", diff);
        end else begin
          if ({bout, ovf, zero, diff} !== exp_q[0]) begin
            errors++;
            $display("FAIL rand_result[%0d]: got %b diff=%h, expected %b diff=%h",
                     received, {bout, ovf, zero}, diff, exp_q[0][34:32], exp_q[0][31:0]);
          end
          void'(exp_q.pop_front());
        end
        received++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(sub_inA, sub_inB, bin));
        accepted++;
        pending = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted != n_ops || received != n_ops || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count: got %0d accepted %0d received, expected %0d each", accepted, received, n_ops);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    tab_a   = '{32'h0000_000A, 32'h0000_0003, 32'h0001_0000, 32'h7FFF_FFFF,
                32'h0000_0055, 32'h0000_0055, 32'hFFFF_FFFF, 32'h8000_0000};
    tab_b   = '{32'h0000_0003, 32'h0000_000A, 32'h0000_0001, 32'hFFFF_FFFF,
                32'h0000_0055, 32'h0000_0054, 32'h0000_0000, 32'h7FFF_FFFF};
    tab_bin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tab_exp = '{{3'b000, 32'h0000_0007},
                {3'b100, 32'hFFFF_FFF9},
                {3'b000, 32'h0000_FFFF},
                {3'b110, 32'h8000_0000},
                {3'b100, 32'hFFFF_FFFF},
                {3'b001, 32'h0000_0000},
                {3'b000, 32'hFFFF_FFFE},
                {3'b010, 32'h0000_0001}};

    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
